// File: rtl/intersection_gate_pkg.sv
// Shared definitions for the stop-light interface: light codes, approach indices, turn
// encodings and the admission FSM state encoding.
package intersection_gate_pkg;

  localparam logic [2:0] LightStop      = 3'b000;
  localparam logic [2:0] LightFwdOnly   = 3'b001;
  localparam logic [2:0] LightLeftOnly  = 3'b010;
  localparam logic [2:0] LightRightOnly = 3'b011;
  localparam logic [2:0] LightGo        = 3'b100;

  localparam logic [1:0] ApprN = 2'd0;
  localparam logic [1:0] ApprS = 2'd1;
  localparam logic [1:0] ApprE = 2'd2;
  localparam logic [1:0] ApprW = 2'd3;

  localparam logic [1:0] TurnFwd   = 2'b00;
  localparam logic [1:0] TurnLeft  = 2'b01;
  localparam logic [1:0] TurnRight = 2'b10;
  localparam logic [1:0] TurnRsvd  = 2'b11;

  typedef enum logic {StIdle, StCrossing} state_e;

endpackage

// File: rtl/intersection_gate_light_permit.sv
// Decodes one approach's light code against a requested turn: returns whether the turn is
// permitted and whether the code itself is illegal.
module light_permit
  import intersection_gate_pkg::*;
(
  input  logic [2:0] code_i,
  input  logic [1:0] turn_i,
  output logic       permit_o,
  output logic       illegal_o
);

  always_comb begin
    permit_o  = 1'b0;
    illegal_o = 1'b0;
    case (code_i)
      LightStop:      permit_o = 1'b0;
      LightFwdOnly:   permit_o = (turn_i == TurnFwd);
      LightLeftOnly:  permit_o = (turn_i == TurnLeft);
      LightRightOnly: permit_o = (turn_i == TurnRight);
      LightGo:        permit_o = (turn_i != TurnRsvd);
      default:        illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/intersection_gate.sv
// Admission controller: lets at most one car at a time into the intersection, holds it busy
// for CrossCycles cycles, and records light conflicts and illegal codes in sticky flags.
module intersection_gate
  import intersection_gate_pkg::*;
#(
  parameter int unsigned CrossCycles = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  light_n_i,
  input  logic [2:0]  light_s_i,
  input  logic [2:0]  light_e_i,
  input  logic [2:0]  light_w_i,
  input  logic [3:0]  req_valid_i,
  input  logic [7:0]  req_turn_i,
  output logic [3:0]  req_ready_o,
  output logic        busy_o,
  output logic [1:0]  cross_dir_o,
  output logic [1:0]  cross_turn_o,
  output logic [15:0] pass_count_o,
  output logic        conflict_o,
  output logic        illegal_code_o
);

  localparam logic [7:0] TimerLoad = 8'(CrossCycles - 1);

  logic [3:0][2:0] lights;
  logic [3:0]      permit;
  logic [3:0]      illegal;
  logic [2:0]      non_stop_cnt;
  logic            any_illegal;
  logic [3:0]      admit_vec;
  logic [1:0]      admit_idx;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  turn_q, turn_d;
  logic [15:0] pass_count_q, pass_count_d;
  logic        conflict_q, conflict_d;
  logic        illegal_q, illegal_d;

  assign lights = {light_w_i, light_e_i, light_s_i, light_n_i};

  for (genvar g = 0; g < 4; g++) begin : g_permit
    light_permit u_light_permit (
      .code_i    (lights[g]),
      .turn_i    (req_turn_i[2*g +: 2]),
      .permit_o  (permit[g]),
      .illegal_o (illegal[g])
    );
  end

  always_comb begin
    non_stop_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      non_stop_cnt = non_stop_cnt + 3'(lights[i] != LightStop);
    end
  end

  assign any_illegal = |illegal;

  // Permit requires a non-Stop light, so with at most one non-Stop light only one bit can rise.
  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && non_stop_cnt <= 3'd1 && !any_illegal) begin
      req_ready_o = req_valid_i & permit;
    end
  end

  assign admit_vec = req_valid_i & req_ready_o;

  always_comb begin
    admit_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (admit_vec[i]) admit_idx = 2'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    dir_d        = dir_q;
    turn_d       = turn_q;
    pass_count_d = pass_count_q;
    unique case (state_q)
      StIdle: begin
        if (|admit_vec) begin
          state_d      = StCrossing;
          timer_d      = TimerLoad;
          dir_d        = admit_idx;
          turn_d       = req_turn_i[2*admit_idx +: 2];
          pass_count_d = pass_count_q + 16'd1;
        end
      end
      StCrossing: begin
        if (timer_q == 8'd0) begin
          state_d = StIdle;
          dir_d   = '0;
          turn_d  = '0;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign conflict_d = conflict_q | (non_stop_cnt >= 3'd2);
  assign illegal_d  = illegal_q | any_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      dir_q        <= '0;
      turn_q       <= '0;
      pass_count_q <= '0;
      conflict_q   <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      turn_q       <= turn_d;
      pass_count_q <= pass_count_d;
      conflict_q   <= conflict_d;
      illegal_q    <= illegal_d;
    end
  end

  assign busy_o         = (state_q == StCrossing);
  assign cross_dir_o    = dir_q;
  assign cross_turn_o   = turn_q;
  assign pass_count_o   = pass_count_q;
  assign conflict_o     = conflict_q;
  assign illegal_code_o = illegal_q;

endmodule

// File: tb/tb_intersection_gate.sv
// Directed bench for intersection_gate: a table of combinational ready vectors plus
// hand-written sequences for crossing timing, sticky flags, reset and counter wrap.
module tb_intersection_gate;

  logic        clk;
  logic        rst;
  logic [2:0]  light_n, light_s, light_e, light_w;
  logic [3:0]  req_valid;
  logic [7:0]  req_turn;
  logic [3:0]  req_ready;
  logic        busy;
  logic [1:0]  cross_dir;
  logic [1:0]  cross_turn;
  logic [15:0] pass_count;
  logic        conflict;
  logic        illegal_code;

  int checks   = 0;
  int failures = 0;

  intersection_gate #(
    .CrossCycles (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .light_n_i      (light_n),
    .light_s_i      (light_s),
    .light_e_i      (light_e),
    .light_w_i      (light_w),
    .req_valid_i    (req_valid),
    .req_turn_i     (req_turn),
    .req_ready_o    (req_ready),
    .busy_o         (busy),
    .cross_dir_o    (cross_dir),
    .cross_turn_o   (cross_turn),
    .pass_count_o   (pass_count),
    .conflict_o     (conflict),
    .illegal_code_o (illegal_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    light_n   = 3'b000;
    light_s   = 3'b000;
    light_e   = 3'b000;
    light_w   = 3'b000;
    req_valid = 4'b0000;
    req_turn  = 8'h00;
  endtask

  typedef struct {
    logic [2:0] n, s, e, w;
    logic [3:0] valid;
    logic [7:0] turn;
    logic [3:0] ready;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                              input logic [2:0] w, input logic [3:0] valid,
                              input logic [7:0] turn, input logic [3:0] ready);
    vec_t v;
    v.n = n; v.s = s; v.e = e; v.w = w;
    v.valid = valid; v.turn = turn; v.ready = ready;
    return v;
  endfunction

  initial begin
    // Codes: Stop 0, Fwd 1, Left 2, Right 3, Go 4.
    vecs[0]  = mk(3'd4, 3'd0, 3'd0, 3'd0, 4'b0001, 8'b0000_0001, 4'b0001);
    vecs[1]  = mk(3'd4, 3'd0, 3'd0, 3'd0, 4'b0001, 8'b0000_0011, 4'b0000);
    vecs[2]  = mk(3'd0, 3'd1, 3'd0, 3'd0, 4'b0010, 8'b0000_0000, 4'b0010);
    vecs[3]  = mk(3'd0, 3'd0, 3'd2, 3'd0, 4'b0100, 8'b0000_0000, 4'b0000);
    vecs[4]  = mk(3'd0, 3'd0, 3'd2, 3'd0, 4'b0100, 8'b0001_0000, 4'b0100);
    vecs[5]  = mk(3'd0, 3'd0, 3'd0, 3'd3, 4'b1000, 8'b1000_0000, 4'b1000);
    vecs[6]  = mk(3'd0, 3'd0, 3'd0, 3'd3, 4'b1000, 8'b0000_0000, 4'b0000);
    vecs[7]  = mk(3'd4, 3'd1, 3'd0, 3'd0, 4'b0011, 8'b0000_0000, 4'b0000);
    vecs[8]  = mk(3'd4, 3'd0, 3'd0, 3'd5, 4'b1001, 8'b0000_0000, 4'b0000);
    vecs[9]  = mk(3'd0, 3'd0, 3'd4, 3'd0, 4'b1111, 8'b0000_0000, 4'b0100);
    vecs[10] = mk(3'd0, 3'd0, 3'd0, 3'd0, 4'b1111, 8'b0000_0000, 4'b0000);
    vecs[11] = mk(3'd4, 3'd0, 3'd0, 3'd0, 4'b0000, 8'b0000_0000, 4'b0000);
    vecs[12] = mk(3'd0, 3'd4, 3'd0, 3'd0, 4'b0010, 8'b0000_1000, 4'b0010);

    // Reset with random inputs: registered outputs stay at zero.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      light_n   = 3'($urandom_range(0, 7));
      light_s   = 3'($urandom_range(0, 7));
      light_e   = 3'($urandom_range(0, 7));
      light_w   = 3'($urandom_range(0, 7));
      req_valid = 4'($urandom);
      req_turn  = 8'($urandom);
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dir_turn", 32'({cross_dir, cross_turn}), 32'd0);
      check("rst_pass", 32'(pass_count), 32'd0);
      check("rst_flags", 32'({conflict, illegal_code}), 32'd0);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // Combinational ready table, each vector removed again before the next rising edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      light_n = vecs[i].n; light_s = vecs[i].s; light_e = vecs[i].e; light_w = vecs[i].w;
      req_valid = vecs[i].valid; req_turn = vecs[i].turn;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      #1;
      idle_inputs();
    end
    @(posedge clk); #1;
    check("table_no_admit", 32'(pass_count), 32'd0);
    check("table_no_flags", 32'({conflict, illegal_code}), 32'd0);

    // Admission on N, left turn; request held through the crossing.
    @(negedge clk);
    light_n = 3'd4; req_valid = 4'b0001; req_turn = 8'b0000_0001;
    #1 check("adm_ready_same_cycle", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("adm_busy_%0d", k), 32'(busy), 32'd1);
      check($sformatf("adm_ready_blocked_%0d", k), 32'(req_ready), 32'd0);
      check($sformatf("adm_dir_turn_%0d", k), 32'({cross_dir, cross_turn}), 32'b0001);
      @(posedge clk); #1;
    end
    check("adm_idle_busy", 32'(busy), 32'd0);
    check("adm_idle_dir_turn", 32'({cross_dir, cross_turn}), 32'd0);
    check("adm_pass", 32'(pass_count), 32'd1);
    check("adm_ready_again", 32'(req_ready), 32'b0001);
    idle_inputs();

    // Two non-Stop lights: blocked, conflict sticks after lights recover.
    @(negedge clk);
    light_n = 3'd4; light_s = 3'd1; req_valid = 4'b0011; req_turn = 8'h00;
    #1 check("conf_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("conf_set", 32'(conflict), 32'd1);
    check("conf_no_admit", 32'({busy, pass_count}), 32'({1'b0, 16'd1}));
    @(negedge clk);
    light_s = 3'd0; req_valid = 4'b0000;
    @(posedge clk); #1;
    check("conf_sticky", 32'(conflict), 32'd1);

    // Illegal code on W also blocks the legal N request.
    @(negedge clk);
    light_n = 3'd4; light_w = 3'd5; req_valid = 4'b1001; req_turn = 8'h00;
    #1 check("ill_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("ill_set", 32'(illegal_code), 32'd1);
    check("ill_no_admit", 32'({busy, pass_count}), 32'({1'b0, 16'd1}));
    idle_inputs();

    // Asynchronous reset clears the sticky flags without a clock edge.
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_clears_flags", 32'({conflict, illegal_code}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset on the second busy cycle of an E right-turn crossing.
    @(negedge clk);
    light_e = 3'd4; req_valid = 4'b0100; req_turn = 8'b0010_0000;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    check("mid_busy", 32'({busy, cross_dir, cross_turn, pass_count}),
          32'({1'b1, 2'd2, 2'b10, 16'd1}));
    rst = 1'b0;
    #1 check("mid_rst", 32'({busy, cross_dir, cross_turn, pass_count}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.pass_count_q = 16'hFFFF;
    #1 release dut.pass_count_q;
    #1 check("wrap_preload", 32'(pass_count), 32'hFFFF);
    @(negedge clk);
    light_s = 3'd4; req_valid = 4'b0010; req_turn = 8'b0000_0000;
    @(posedge clk); #1;
    check("wrap_pass", 32'(pass_count), 32'h0000);
    check("wrap_busy_dir", 32'({busy, cross_dir}), 32'({1'b1, 2'd1}));
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_gate.md
# intersection_gate

Admission controller at the consumer end of the stop-light interface. It takes the four 3-bit light commands produced by a light controller and per-approach car requests with an intended turn. It admits at most one car at a time into the intersection via valid/ready handshakes, holds the intersection busy while the car crosses, and flags illegal light codes or conflicting light commands.

## Interface
- CROSS_CYCLES, 4: cycles an admitted car occupies the intersection; legal range 1..255.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- light_n / light_s / light_e / light_w  in  3 each  light command per approach: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100; codes 101..111 are illegal.
- req_valid  in  4  car waiting per approach; bit 0=N, 1=S, 2=E, 3=W.
- req_turn  in  8  2 bits per approach, same order, approach i in [2i+1:2i]: 00 forward, 01 left, 10 right, 11 reserved.
- req_ready  out  4  admission; a car is admitted on a cycle where req_valid[i] & req_ready[i] are both 1.
- busy  out  1  intersection occupied.
- cross_dir  out  2  approach index of the car currently crossing; 0 when idle.
- cross_turn  out  2  turn of the car currently crossing; 0 when idle.
- pass_count  out  16  admitted cars, wraps modulo 2^16.
- conflict  out  1  sticky; more than one approach was non-Stop in the same cycle.
- illegal_code  out  1  sticky; any light input carried 101..111.

## Operation
- FSM states:
  - IDLE: busy=0; ready logic active.
  - CROSSING: busy=1; req_ready=0.
- Permit per approach:
  - Go permits turns 00/01/10.
  - Forward_only permits 00 only.
  - Left_only permits 01 only.
  - Right_only permits 10 only.
  - Stop and illegal codes permit nothing.
  - Turn 11 is never permitted.
- Non-Stop count: the number of light inputs not equal to 000 (illegal codes count as non-Stop).
- req_ready[i] is asserted when all of the following hold:
  - state is IDLE;
  - the non-Stop count is at most 1;
  - no light input is illegal;
  - req_valid[i] is 1;
  - the light permits req_turn[i].
- At most one req_ready bit can be high in any cycle.
- req_ready is combinational from state and inputs. Requesters hold req_valid and req_turn stable until admitted. Withdrawing a request before admission is allowed and has no side effect.
- On admission:
  - go to CROSSING;
  - load timer with CROSS_CYCLES-1;
  - latch cross_dir and cross_turn;
  - increment pass_count.
- In CROSSING:
  - timer decrements each cycle;
  - on the cycle timer==0, next state is IDLE, and cross_dir/cross_turn clear to 0.
- Light changes during CROSSING are ignored. An admitted car always completes its crossing; there is no abort.
- conflict is set in any cycle with non-Stop count ≥2, regardless of state.
- illegal_code is set in any cycle with a code of 101..111.
- conflict and illegal_code are both cleared only by rst.
- pass_count wraps from 0xFFFF to 0x0000 without a flag.

## Timing
- Reset values: state IDLE, timer 0, busy 0, cross_dir 0, cross_turn 0, pass_count 0, conflict 0, illegal_code 0. req_ready evaluates from IDLE.
- Admission latency: req_ready rises in the same cycle as its enabling inputs (0 cycles).
- busy is 1 for exactly CROSS_CYCLES cycles following the admission edge.
- The next admission is possible in the first IDLE cycle, so the minimum admission spacing is CROSS_CYCLES+1 cycles.
- CROSS_CYCLES=1 means busy for one cycle.
- Sticky flags assert on the clock edge after the offending input cycle.
- Reset mid-crossing returns all state to reset values asynchronously; no admission is recorded for that cycle.

## Structure
- Shared package holds:
  - light code constants (Stop, Forward_only, Left_only, Right_only, Go);
  - approach indices N=0, S=1, E=2, W=3;
  - turn encodings;
  - FSM state encoding.
- The light controller uses the same light code constants.
- One sub-module, light_permit: a combinational decoder taking (3-bit code, 2-bit turn) and returning (permit, illegal). It is instantiated four times.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0; req_ready=0 while busy is irrelevant.
- light_n=Go, req_valid=0001, req_turn[1:0]=01, CROSS_CYCLES=4 → req_ready=0001 in the same cycle; busy=1 for 4 cycles with cross_dir=0, cross_turn=01; pass_count=1; IDLE on cycle 5.
- light_e=Left_only, req_valid=0100, turn=00 → req_ready stays 0; change turn to 01 → req_ready=0100 the same cycle.
- light_n=Go and light_s=Forward_only together, both requesting forward → no req_ready; conflict=1 next edge and still 1 after lights return to a single Go.
- light_w=101 with a W request → no admission, illegal_code=1; request on a legal approach in the same cycle also blocked.
- Reset asserted at the 2nd busy cycle → busy, cross_dir, pass_count go to 0 immediately. Separately, preload 0xFFFF admissions (or force) → next admission gives pass_count=0x0000.
